fp_normalize_round: RTL and testbench

FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

---
 rtl/float_struct_pkg.sv | 50 +++++
 rtl/lzc28.sv | 18 +
 rtl/fp_normalize_round.sv | 130 +++++++++++++
 tb/tb_fp_normalize_round.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/float_struct_pkg.sv
// Shared types for the float normalize/round pipeline: result classes,
// IEEE-754 single constants and the inter-stage register layouts.
package float_struct;

  localparam int MANT_WIDTH = 28;
  localparam int EXP_WIDTH  = 10;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_NAN = 2'b01,
    ST_INF = 2'b10,
    ST_NUL = 2'b11
  } states_t;

  // Stage 1: raw operand plus leading-one position.
  typedef struct packed {
    logic                         vld;
    logic                         sign;
    logic signed [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0]        mant;
    states_t                      st;
    logic [4:0]                   lead;
    logic                         zero;
  } s1_t;

  // Stage 2: mantissa normalized so the hidden bit sits at [26].
  typedef struct packed {
    logic                         vld;
    logic                         sign;
    logic signed [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0]        mant;
    states_t                      st;
    logic                         zero;
  } s2_t;

  // Stage 3: rounded fraction and exponent, not yet range-checked.
  typedef struct packed {
    logic                         vld;
    logic                         sign;
    logic signed [EXP_WIDTH-1:0]  exp;
    logic [22:0]                  frac;
    states_t                      st;
    logic                         zero;
  } s3_t;

endpackage

// File: rtl/lzc28.sv
// Leading-one detector for the 28-bit raw mantissa: position of the
// highest set bit, plus a flag when no bit is set.
module lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  pos,
  output logic        zero
);

  always_comb begin
    pos = 5'd0;
    // Ascending scan so the highest set bit is the last assignment.
    for (int i = 0; i < 28; i++) begin
      if (value[i]) pos = 5'(i);
    end
    zero = ~|value;
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-adder normalize, round-to-nearest-even and pack into IEEE-754
// single precision; four registered steps, one result per input.
module fp_normalize_round
  import float_struct::*;
#(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [1:0]        in_state,
  output logic [31:0]       result,
  output logic [1:0]        state,
  output logic              res_vld
);

  s1_t s1_reg, s1_next;
  s2_t s2_reg, s2_next;
  s3_t s3_reg, s3_next;

  logic [4:0] lead;
  logic       lead_zero;

  lzc28 u_lzc (
    .value (in_mant),
    .pos   (lead),
    .zero  (lead_zero)
  );

  always_comb begin
    s1_next      = '0;
    s1_next.vld  = in_vld;
    s1_next.sign = in_sign;
    s1_next.exp  = $signed(in_exp);
    s1_next.mant = in_mant;
    s1_next.st   = states_t'(in_state);
    s1_next.lead = lead;
    s1_next.zero = lead_zero;
  end

  logic [4:0] shift_amt;

  always_comb begin
    s2_next      = '0;
    s2_next.vld  = s1_reg.vld;
    s2_next.sign = s1_reg.sign;
    s2_next.st   = s1_reg.st;
    s2_next.zero = s1_reg.zero;
    s2_next.exp  = s1_reg.exp;
    s2_next.mant = s1_reg.mant;
    shift_amt    = 5'd26 - s1_reg.lead;
    if (s1_reg.mant[27]) begin
      // Carry out of the adder: drop one bit but keep it in the sticky.
      s2_next.mant = {1'b0, s1_reg.mant[27:2], s1_reg.mant[1] | s1_reg.mant[0]};
      s2_next.exp  = s1_reg.exp + EXP_WIDTH'(1);
    end else if (!s1_reg.zero && s1_reg.lead < 5'd26) begin
      s2_next.mant = s1_reg.mant << shift_amt;
      s2_next.exp  = s1_reg.exp - $signed({{(EXP_WIDTH-5){1'b0}}, shift_amt});
    end
  end

  logic        round_inc;
  logic [24:0] rounded;

  always_comb begin
    s3_next      = '0;
    s3_next.vld  = s2_reg.vld;
    s3_next.sign = s2_reg.sign;
    s3_next.st   = s2_reg.st;
    s3_next.zero = s2_reg.zero;
    round_inc    = s2_reg.mant[2] & (s2_reg.mant[1] | s2_reg.mant[0] | s2_reg.mant[3]);
    rounded      = {1'b0, s2_reg.mant[26:3]} + {24'd0, round_inc};
    s3_next.frac = rounded[22:0];
    s3_next.exp  = s2_reg.exp;
    if (rounded[24]) begin
      s3_next.frac = 23'd0;
      s3_next.exp  = s2_reg.exp + EXP_WIDTH'(1);
    end
  end

  logic [31:0] pack_res;
  states_t     pack_st;

  always_comb begin
    pack_res = {s3_reg.sign, s3_reg.exp[7:0], s3_reg.frac};
    pack_st  = ST_OK;
    if (s3_reg.st == ST_NAN) begin
      pack_res = QNAN;
      pack_st  = ST_NAN;
    end else if (s3_reg.st == ST_INF) begin
      pack_res = {s3_reg.sign, 8'hFF, 23'd0};
      pack_st  = ST_INF;
    end else if (s3_reg.st == ST_NUL || s3_reg.zero) begin
      pack_res = {s3_reg.sign, 31'd0};
      pack_st  = ST_NUL;
    end else if (s3_reg.exp >= $signed(EXP_WIDTH'(EXP_MAX))) begin
      pack_res = {s3_reg.sign, 8'hFF, 23'd0};
      pack_st  = ST_INF;
    end else if (s3_reg.exp <= $signed(EXP_WIDTH'(0))) begin
      // No subnormal output: anything below the normal range flushes.
      pack_res = {s3_reg.sign, 31'd0};
      pack_st  = ST_NUL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg  <= '0;
      s2_reg  <= '0;
      s3_reg  <= '0;
      result  <= 32'd0;
      state   <= ST_OK;
      res_vld <= 1'b0;
    end else begin
      s1_reg  <= s1_next;
      s2_reg  <= s2_next;
      s3_reg  <= s3_next;
      res_vld <= s3_reg.vld;
      if (s3_reg.vld) begin
        result <= pack_res;
        state  <= pack_st;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round: expected results are queued
// with their due cycle when driven and compared when the DUT produces them.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic [1:0]  in_state;
  logic [31:0] result;
  logic [1:0]  state;
  logic        res_vld;

  fp_normalize_round dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_sign  (in_sign),
    .in_exp   (in_exp),
    .in_mant  (in_mant),
    .in_state (in_state),
    .result   (result),
    .state    (state),
    .res_vld  (res_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  st;
    int          due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   rst_prev = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h (cycle %0d)", tag, got, want, cyc);
  endtask

  // Independent reference: integer normalize, then nearest-even rounding.
  function automatic logic [33:0] model(input logic sign, input int e,
                                        input logic [27:0] mant, input logic [1:0] st);
    int m, f, grs;
    if (st == 2'b01) return {2'b01, 32'h7FC00000};
    if (st == 2'b10) return {2'b10, sign, 8'hFF, 23'd0};
    if (st == 2'b11 || mant == 28'd0) return {2'b11, sign, 31'd0};
    m = int'(mant);
    if (m >= (1 << 27)) begin
      m = (m >> 1) | (m & 1);
      e++;
    end else begin
      while (m < (1 << 26)) begin
        m = m << 1;
        e--;
      end
    end
    f   = m >> 3;
    grs = m & 7;
    if (grs > 4 || (grs == 4 && (f & 1) == 1)) f++;
    if (f >= (1 << 24)) begin
      f = f >> 1;
      e++;
    end
    if (e >= 255) return {2'b10, sign, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b11, sign, 31'd0};
    return {2'b00, sign, e[7:0], f[22:0]};
  endfunction

  // One clock: check what the DUT shows now, then drive the next cycle.
  task automatic step(input logic vld, input logic sign, input int e,
                      input logic [27:0] mant, input logic [1:0] st, input bit do_rst);
    logic [33:0] m;
    exp_t        x;
    @(negedge clk);
    cyc++;
    if (rst_prev) begin
      check_val("rst_result", result, 32'd0);
      check_val("rst_state", {30'd0, state}, 32'd0);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      x = q.pop_front();
      check_val("res_vld", {31'd0, res_vld}, 32'd1);
      check_val("result", result, x.res);
      check_val("state", {30'd0, state}, {30'd0, x.st});
      $display("cycle %0d: result %08h state %0d (expected %08h/%0d)", cyc, result, state, x.res, x.st);
    end else begin
      check_val("idle_vld", {31'd0, res_vld}, 32'd0);
    end
    if (do_rst) q.delete();
    rst_prev = do_rst;
    rst      = do_rst;
    in_vld   = vld;
    in_sign  = sign;
    in_exp   = e[9:0];
    in_mant  = mant;
    in_state = st;
    if (vld && !do_rst) begin
      m     = model(sign, e, mant, st);
      x.res = m[31:0];
      x.st  = m[33:32];
      x.due = cyc + 4;
      q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 28'd0, 2'b00, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    in_vld   = 1'b0;
    in_sign  = 1'b0;
    in_exp   = '0;
    in_mant  = '0;
    in_state = 2'b00;
    repeat (2) @(negedge clk);
    check_val("reset_vld", {31'd0, res_vld}, 32'd0);
    check_val("reset_result", result, 32'd0);
    check_val("reset_state", {30'd0, state}, 32'd0);

    step(1'b1, 1'b0, 127, 28'h8000000, 2'b00, 1'b0);
    step(1'b1, 1'b0, 127, 28'h0000008, 2'b00, 1'b0);
    step(1'b1, 1'b0, 127, 28'h4000004, 2'b00, 1'b0);
    step(1'b1, 1'b0, 127, 28'h400000C, 2'b00, 1'b0);
    step(1'b1, 1'b0, 127, 28'h7FFFFFE, 2'b00, 1'b0);
    step(1'b1, 1'b0, 254, 28'h8000000, 2'b00, 1'b0);
    step(1'b1, 1'b1, 127, 28'h4000000, 2'b01, 1'b0);
    step(1'b1, 1'b1, 127, 28'h0000000, 2'b00, 1'b0);
    step(1'b1, 1'b1, 50,  28'h1234567, 2'b10, 1'b0);
    step(1'b1, 1'b0, 50,  28'h1234567, 2'b11, 1'b0);
    step(1'b1, 1'b0, 10,  28'h0000001, 2'b00, 1'b0);
    step(1'b1, 1'b1, -32, 28'h8000000, 2'b00, 1'b0);
    step(1'b1, 1'b0, 300, 28'h0000100, 2'b00, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1,   28'h7FFFFFC, 2'b00, 1'b0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      logic [27:0] mr;
      mr = 28'($urandom() >> $urandom_range(4, 31));
      step(1'b1, 1'($urandom()), int'($urandom_range(0, 332)) - 32, mr,
           ($urandom_range(0, 7) == 0) ? 2'($urandom()) : 2'b00, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(6);

    // Back-to-back stream with reset landing on its third cycle.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 127 + k, 28'h4000000 + 28'(k * 8), 2'b00, k == 2);
      if (k == 2) begin
        idle(6);
        step(1'b1, 1'b1, 127, 28'h8000000, 2'b00, 1'b0);
        idle(6);
        break;
      end
    end

    if (q.size() != 0) begin
      check_val("drain", q.size(), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
